round_ctrl: RTL and testbench

ROUND_CTRL -- requirements
Module: round_ctrl

---
 rtl/round_ctrl.sv | 132 +++++++++++++
 tb/tb_round_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// Round controller for a timed quiz game: sequences rounds, tracks score.
// Optional freeze input enabled by defining ROUND_CTRL_PAUSE_EN.
module round_ctrl #(
    parameter int P_ROUNDS = 5,
    parameter int P_W      = 4
) (
    input  logic           clkt,
    input  logic           R,
    input  logic           start,
    input  logic           done,
    input  logic           hit,
    input  logic           end_time,
`ifdef ROUND_CTRL_PAUSE_EN
    input  logic           pause,
`endif
    output logic           en_t,
    output logic           rst_t,
    output logic [P_W-1:0] round,
    output logic [P_W-1:0] score,
    output logic           playing,
    output logic           timeout,
    output logic           fin
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PLAY,
        S_CHECK,
        S_TOUT,
        S_FINISH
    } state_t;

    localparam logic [P_W-1:0] LAST_RND  = P_W'(P_ROUNDS - 1);
    localparam logic [P_W-1:0] MAX_SCORE = P_W'(P_ROUNDS);

    state_t         state_q, state_d;
    logic [P_W-1:0] round_q, round_d;
    logic [P_W-1:0] score_q, score_d;
    logic           hit_q, hit_d;
    logic           frz;

`ifdef ROUND_CTRL_PAUSE_EN
    assign frz = pause;
`else
    assign frz = 1'b0;
`endif

    // State, round, score and latched answer registers
    always_ff @(posedge clkt or posedge R) begin
        if (R) begin
            state_q <= S_IDLE;
            round_q <= '0;
            score_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            score_q <= score_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state logic; round advance is shared by CHECK and TOUT
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        score_d = score_q;
        hit_d   = hit_q;
        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_d = S_SETUP;
                    round_d = '0;
                    score_d = '0;
                    hit_d   = 1'b0;
                end
            end
            S_SETUP: state_d = S_PLAY;
            S_PLAY: begin
                if (!frz) begin
                    if (done) begin
                        state_d = S_CHECK;
                        hit_d   = hit;
                    end else if (end_time) begin
                        state_d = S_TOUT;
                    end
                end
            end
            S_CHECK, S_TOUT: begin
                if (state_q == S_CHECK && hit_q && score_q < MAX_SCORE) begin
                    score_d = score_q + P_W'(1);
                end
                if (round_q >= LAST_RND) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_SETUP;
                    round_d = round_q + P_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; a pause only gates the time counter enable
    always_comb begin
        en_t    = 1'b0;
        rst_t   = 1'b0;
        playing = 1'b0;
        timeout = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            S_IDLE:   rst_t = 1'b1;
            S_SETUP:  rst_t = 1'b1;
            S_PLAY: begin
                en_t    = !frz;
                playing = 1'b1;
            end
            S_CHECK:  ;
            S_TOUT:   timeout = 1'b1;
            S_FINISH: begin
                rst_t = 1'b1;
                fin   = 1'b1;
            end
            default:  rst_t = 1'b1;
        endcase
    end

    assign round = round_q;
    assign score = score_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: games are expanded into per-cycle
// input/expected-output vectors; a monitor pops and compares each cycle.
module tb_round_ctrl;

    localparam int NR = 5;

    typedef struct {
        logic       en;
        logic       rst;
        logic       rst_care;
        logic       pl;
        logic       to;
        logic       fn;
        logic [3:0] rnd;
        logic [3:0] scr;
    } exp_t;

    logic       clkt = 1'b0;
    logic       R = 1'b1;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic       hit = 1'b0;
    logic       end_time = 1'b0;
    logic       pause_drv = 1'b0;
    logic       en_t, rst_t, playing, timeout, fin;
    logic [3:0] round, score;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;

    int r_m = 0;
    int s_m = 0;
    bit fin_m = 0;

    round_ctrl #(.P_ROUNDS(NR), .P_W(4)) dut (
        .clkt(clkt),
        .R(R),
        .start(start),
        .done(done),
        .hit(hit),
        .end_time(end_time),
`ifdef ROUND_CTRL_PAUSE_EN
        .pause(pause_drv),
`endif
        .en_t(en_t),
        .rst_t(rst_t),
        .round(round),
        .score(score),
        .playing(playing),
        .timeout(timeout),
        .fin(fin)
    );

    always #5 clkt = ~clkt;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic exp_t mk(logic en, logic rs, logic rc,
                                logic pl, logic to, logic fn);
        exp_t e;
        e.en = en; e.rst = rs; e.rst_care = rc;
        e.pl = pl; e.to = to; e.fn = fn;
        e.rnd = 4'(r_m); e.scr = 4'(s_m);
        return e;
    endfunction

    // expected describes outputs during the cycle the inputs are applied
    task automatic step(input exp_t e, input logic st, input logic dn,
                        input logic ht, input logic et, input logic ps,
                        input logic rr);
        @(negedge clkt);
        expq.push_back(e);
        R = rr; start = st; done = dn; hit = ht;
        end_time = et; pause_drv = ps;
    endtask

    task automatic do_reset(input int n);
        r_m = 0; s_m = 0; fin_m = 0;
        for (int i = 0; i < n; i++)
            step(mk(0, 1, 1, 0, 0, 0), rb(), rb(), rb(), rb(), 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(mk(0, 1, 1, 0, 0, fin_m), 0, rb(), rb(), rb(), 0, 0);
    endtask

    task automatic start_game();
        step(mk(0, 1, 1, 0, 0, fin_m), 1, rb(), rb(), rb(), 0, 0);
        r_m = 0; s_m = 0; fin_m = 0;
    endtask

    // oc: 0 correct, 1 wrong, 2 timeout, 3 tie correct, 4 pause+timeout
    task automatic play_round(input int oc, input int wt);
        logic dn, ht, et;
        step(mk(0, 1, 1, 0, 0, 0), rb(), rb(), rb(), rb(), 0, 0);
        for (int i = 0; i < wt; i++)
            step(mk(1, 0, 1, 1, 0, 0), rb(), 0, rb(), 0, 0, 0);
`ifdef ROUND_CTRL_PAUSE_EN
        if (oc == 4)
            for (int i = 0; i < 3; i++)
                step(mk(0, 0, 1, 1, 0, 0), rb(), rb(), rb(), 1, 1, 0);
`endif
        dn = (oc == 0 || oc == 1 || oc == 3);
        ht = dn ? (oc != 1) : rb();
        et = (oc >= 2) ? 1'b1 : rb();
        step(mk(1, 0, 1, 1, 0, 0), rb(), dn, ht, et, 0, 0);
        step(mk(0, 0, 0, 0, !dn, 0), rb(), rb(), rb(), rb(), 0, 0);
        if (dn && ht) s_m++;
        if (r_m == NR - 1) fin_m = 1;
        else r_m++;
    endtask

    task automatic game(input int oc[NR], input int maxw);
        start_game();
        for (int i = 0; i < NR; i++)
            play_round(oc[i], $urandom_range(0, maxw));
    endtask

    // Monitor: compare DUT outputs with the oldest expectation
    initial begin
        exp_t e;
        logic rs_ok;
        forever begin
            @(negedge clkt);
            #1;
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL underflow t=%0t: no expected vector queued", $time);
            end else begin
                e = expq.pop_front();
                rs_ok = !e.rst_care || (rst_t === e.rst);
                if (en_t !== e.en || !rs_ok || playing !== e.pl ||
                    timeout !== e.to || fin !== e.fn ||
                    round !== e.rnd || score !== e.scr) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got en=%b rst=%b pl=%b to=%b fin=%b rnd=%0d scr=%0d want en=%b rst=%b(care %b) pl=%b to=%b fin=%b rnd=%0d scr=%0d",
                             $time, en_t, rst_t, playing, timeout, fin,
                             round, score, e.en, e.rst, e.rst_care, e.pl,
                             e.to, e.fn, e.rnd, e.scr);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int oc[NR];
        do_reset(2);
        idle(2);

        // mid-game reset at round 2 with score 1
        start_game();
        play_round(0, 1);
        play_round(2, 0);
        step(mk(0, 1, 1, 0, 0, 0), rb(), rb(), rb(), rb(), 0, 0);
        for (int i = 0; i < 3; i++)
            step(mk(1, 0, 1, 1, 0, 0), rb(), 0, rb(), 0, 0, 0);
        do_reset(1);
        idle(1);

        // all correct
        oc = '{0, 0, 0, 0, 0};
        game(oc, 3);
        idle(2);

        // all timeouts, started from FINISH
        oc = '{2, 2, 2, 2, 2};
        game(oc, 3);
        idle(1);

        // all ties
        oc = '{3, 3, 3, 3, 3};
        game(oc, 2);

        // score 3 then restart straight from FINISH
        oc = '{0, 1, 0, 2, 3};
        game(oc, 2);
        idle(1);

`ifdef ROUND_CTRL_PAUSE_EN
        oc = '{4, 0, 4, 1, 2};
        game(oc, 2);
        idle(1);
`endif

        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < NR; i++)
`ifdef ROUND_CTRL_PAUSE_EN
                oc[i] = $urandom_range(0, 4);
`else
                oc[i] = $urandom_range(0, 3);
`endif
            game(oc, 5);
            idle($urandom_range(0, 2));
        end

        do_reset(1);
        idle(2);

        #2;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d expected vectors unchecked, want 0",
                     expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
